// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the pwm_breathe LED driver.
// PWM_GAMMA_EN selects the gamma-corrected breathe level in pwm_fold.
package pwm_pkg;

  typedef enum logic {
    MODE_STATIC  = 1'b0,
    MODE_BREATHE = 1'b1
  } pwm_mode_e;

  function automatic int pwm_max(input int w);
    return (1 << w) - 1;
  endfunction

  // Evenly spaced phase offset of channel i on a 2^(w+1) step circle.
  function automatic int ch_offset(
    input int i,
    input int w,
    input int ch
  );
    return (i * (1 << (w + 1))) / ch;
  endfunction

endpackage

// File: rtl/pwm_fold.sv
// Triangle fold of the shared breathing phase into one channel level.
// PWM_GAMMA_EN adds a square-law gamma stage after the fold.
module pwm_fold
  import pwm_pkg::*;
#(
  parameter int PWM_W = 8
) (
  input  logic [PWM_W:0]   ph_i,
  input  logic [PWM_W:0]   off_i,
  output logic [PWM_W-1:0] lvl_o
);

  logic [PWM_W:0]   p;
  logic [PWM_W-1:0] fold_lvl;

  assign p = ph_i + off_i;

  assign fold_lvl = p[PWM_W] ? ~p[PWM_W-1:0]
                             : p[PWM_W-1:0];

`ifdef PWM_GAMMA_EN
  logic [2*PWM_W-1:0] base;
  logic [2*PWM_W-1:0] sq;

  // (MAX+1)^2 wraps to 0, so the -1 lands on all-ones and g(MAX)=MAX.
  assign base = {{(PWM_W-1){1'b0}},
                 {1'b0, fold_lvl} + 1'b1};
  assign sq = base * base - 1'b1;
  assign lvl_o = PWM_W'(sq >> PWM_W);
`else
  assign lvl_o = fold_lvl;
`endif

endmodule

// File: rtl/pwm_breathe.sv
// Multi-channel PWM driver with static or breathing duty per channel.
// Build with PWM_GAMMA_EN for gamma-corrected breathing levels.
module pwm_breathe
  import pwm_pkg::*;
#(
  parameter int CH      = 4,
  parameter int PWM_W   = 8,
  parameter int PRESC_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic [CH-1:0]         mode,
  input  logic [CH*PWM_W-1:0]   duty,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_start
);

  localparam logic [PWM_W-1:0] CNT_LAST =
    PWM_W'(pwm_max(PWM_W) - 1);

  logic [PWM_W-1:0]   cnt_q, cnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PWM_W:0]     ph_q, ph_d;
  logic [PWM_W-1:0]   sh_q [CH];
  logic [PWM_W-1:0]   sh_d [CH];
  logic [CH-1:0]      pwm_q, pwm_d;
  logic               ps_q, ps_d;

  logic [PWM_W-1:0]   lvl [CH];
  logic               wrap;
  logic               load;
  logic               adv;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    localparam logic [PWM_W:0] OFF =
      (PWM_W+1)'(ch_offset(g, PWM_W, CH));

    pwm_fold #(
      .PWM_W (PWM_W)
    ) u_fold (
      .ph_i  (ph_q),
      .off_i (OFF),
      .lvl_o (lvl[g])
    );
  end

  assign wrap = (cnt_q == CNT_LAST);
  assign load = !en | wrap;
  assign adv  = en & wrap;

  always_comb begin
    cnt_d = load ? '0 : cnt_q + 1'b1;
  end

  // Exact-match compare: a prescale lowered below presc wraps the counter.
  always_comb begin
    presc_d = presc_q;
    ph_d    = ph_q;
    if (adv) begin
      if (presc_q == prescale) begin
        presc_d = '0;
        ph_d    = ph_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CH; i++) begin
      sh_d[i] = sh_q[i];
      if (load) begin
        unique case (1'b1)
          (mode[i] == MODE_BREATHE):
            sh_d[i] = lvl[i];
          default:
            sh_d[i] = duty[i*PWM_W +: PWM_W];
        endcase
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < CH; i++) begin
      pwm_d[i] = en & (cnt_q < sh_q[i]);
    end
    ps_d = adv;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      presc_q <= '0;
      ph_q    <= '0;
      pwm_q   <= '0;
      ps_q    <= 1'b0;
      for (int i = 0; i < CH; i++) begin
        sh_q[i] <= '0;
      end
    end else begin
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ph_q    <= ph_d;
      pwm_q   <= pwm_d;
      ps_q    <= ps_d;
      for (int i = 0; i < CH; i++) begin
        sh_q[i] <= sh_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_breathe.sv
// Scoreboard bench for pwm_breathe: per-period high counts and
// period_start spacing against a phase/step reference model.
module tb_pwm_breathe;

  localparam int CH      = 4;
  localparam int PWM_W   = 8;
  localparam int PRESC_W = 3;
  localparam int P       = (1 << PWM_W) - 1;
  localparam int PH_N    = 1 << (PWM_W + 1);

  typedef struct packed {
    logic [CH-1:0][15:0] hi;
    logic [31:0]         gap;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                en = 1'b0;
  logic [PRESC_W-1:0]  prescale = '0;
  logic [CH-1:0]       mode = '0;
  logic [CH*PWM_W-1:0] duty = '0;
  logic [CH-1:0]       pwm_out;
  logic                period_start;

  pwm_breathe #(
    .CH      (CH),
    .PWM_W   (PWM_W),
    .PRESC_W (PRESC_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .prescale     (prescale),
    .mode         (mode),
    .duty         (duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];

  task automatic chk(input string nm, input int got,
                     input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  // Monitor: accumulate highs between period_start pulses.
  int   acc [CH];
  int   mgap = 0;
  exp_t me;

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) acc[i] = 0;
      mgap = 0;
    end else begin
      mgap++;
      for (int i = 0; i < CH; i++) acc[i] += int'(pwm_out[i]);
      if (period_start) begin
        if (q.size() == 0) begin
          chk("unexpected_period_start", 1, 0);
        end else begin
          me = q.pop_front();
          for (int i = 0; i < CH; i++)
            chk($sformatf("ch%0d_highs", i), acc[i], int'(me.hi[i]));
          if (me.gap != 0)
            chk("period_gap", mgap, int'(me.gap));
        end
        for (int i = 0; i < CH; i++) acc[i] = 0;
        mgap = 0;
      end
    end
  end

  // Reference model state: breathing step, prescaler, shadows.
  int step = 0;
  int presc = 0;
  int cur [CH];
  int carry [CH];
  int gapv = 0;

  function automatic int lvl_of(input int i, input int s);
    int p, l;
    p = (s + i * PH_N / CH) % PH_N;
    l = (p >= PH_N / 2) ? (PH_N - 1 - p) : p;
`ifdef PWM_GAMMA_EN
    l = ((l + 1) * (l + 1) - 1) >> PWM_W;
`endif
    return l;
  endfunction

  function automatic int sh_of(input int i,
                               input logic [CH-1:0] md,
                               input logic [CH*PWM_W-1:0] dt);
    if (md[i]) return lvl_of(i, step);
    return int'(dt[i*PWM_W +: PWM_W]);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [CH-1:0] md,
                           input logic [CH*PWM_W-1:0] dt,
                           input int pr, input int g);
    mode = md;
    duty = dt;
    prescale = PRESC_W'(pr);
    tick(1);
    for (int i = 0; i < CH; i++) cur[i] = sh_of(i, mode, duty);
    en = 1'b1;
    gapv = g;
  endtask

  task automatic do_period(input int m,
                           input logic [CH-1:0] md,
                           input logic [CH*PWM_W-1:0] dt,
                           input int pr);
    exp_t e;
    tick(m);
    mode = md;
    duty = dt;
    prescale = PRESC_W'(pr);
    tick(P - m);
    for (int i = 0; i < CH; i++) e.hi[i] = 16'(cur[i] + carry[i]);
    e.gap = gapv;
    q.push_back(e);
    for (int i = 0; i < CH; i++) begin
      cur[i] = sh_of(i, mode, duty);
      carry[i] = 0;
    end
    if (presc == int'(prescale)) begin
      presc = 0;
      step = (step + 1) % PH_N;
    end else begin
      presc = (presc + 1) % (1 << PRESC_W);
    end
    gapv = P;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 1'b0;
    tick(1);
    chk("reset_pwm_out", int'(pwm_out), 0);
    chk("reset_period_start", int'(period_start), 0);
    tick(1);
    reset = 1'b0;
    step = 0;
    presc = 0;
    for (int i = 0; i < CH; i++) carry[i] = 0;
  endtask

  function automatic int rm();
    return int'($urandom_range(1, P - 1));
  endfunction

  initial begin
    for (int i = 0; i < CH; i++) begin
      cur[i] = 0;
      carry[i] = 0;
      acc[i] = 0;
    end
    do_reset();

    // Static levels, then ch0 duty changes mid-period at cnt=100.
    start_run(4'h0, {8'd255, 8'd64, 8'd1, 8'd0}, 0, 0);
    do_period(100, 4'h0, {8'd255, 8'd64, 8'd1, 8'd64}, 0);
    do_period(100, 4'h0, {8'd255, 8'd64, 8'd1, 8'd200}, 0);
    do_period(100, 4'h0, {8'd255, 8'd64, 8'd1, 8'd200}, 0);
    do_period(rm(), 4'h0, {8'd255, 8'd64, 8'd1, 8'd200}, 0);

    // Reset mid-period: ch3 is high before the reset is sampled.
    tick(80);
    chk("pwm_before_reset", int'(pwm_out[3]), 1);
    do_reset();

    // Breathing from phase 0: sweep ch0 through the top of the triangle.
    start_run(4'hF, $urandom, 0, 0);
    for (int k = 0; k < 262; k++)
      do_period(rm(), 4'hF, $urandom, 0);
    for (int k = 0; k < 6; k++)
      do_period(rm(), CH'($urandom), $urandom, 0);

    // Prescale 2, then drop to 0 while presc==2 to force the wrap.
    for (int k = 0; k < 6; k++)
      do_period(rm(), 4'hF, $urandom, 2);
    for (int k = 0; k < 4 && presc != 2; k++)
      do_period(rm(), 4'hF, $urandom, 2);
    chk("model_presc_at_switch", presc, 2);
    do_period(rm(), 4'hF, $urandom, 0);
    for (int k = 0; k < 10; k++)
      do_period(rm(), 4'hF, $urandom, 0);

    // Disable at cnt=50 with full duty, resume 20 cycles later.
    do_period(rm(), 4'h0, {CH*PWM_W{1'b1}}, 0);
    tick(50);
    chk("pwm_before_disable", int'(pwm_out), 4'hF);
    for (int i = 0; i < CH; i++)
      carry[i] = (cur[i] < 50) ? cur[i] : 50;
    en = 1'b0;
    tick(1);
    chk("pwm_after_disable", int'(pwm_out), 0);
    chk("ps_after_disable", int'(period_start), 0);
    duty = $urandom;
    tick(18);
    chk("pwm_while_disabled", int'(pwm_out), 0);
    start_run(4'hF, $urandom, 0, 50 + 20 + P);
    for (int k = 0; k < 3; k++)
      do_period(rm(), 4'hF, $urandom, 0);

    tick(3);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_breathe.md
# pwm_breathe

Multi-channel PWM LED driver with per-channel static-duty or breathing mode. It is the parametrised successor of the single-channel breathing-LED PWM. A shared period counter drives CH comparators. A shared triangle-phase generator, paced by a runtime prescaler, supplies breathing levels that are staggered evenly across channels. Duty is double-buffered and changes only at period boundaries, so output waveforms never glitch.

## Interface
- CH, 4: channel count; power of two, 1..2^(PWM_W+1)
- PWM_W, 8: duty/level resolution in bits, ≥2
- PRESC_W, 16: breathing prescaler width
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- en  in  1  run enable
- prescale  in  PRESC_W  breathing step interval: phase advances every prescale+1 periods
- mode  in  CH  per channel: 0 = static, 1 = breathe
- duty  in  CH*PWM_W  static duty; channel i in bits [i*PWM_W +: PWM_W]
- pwm_out  out  CH  registered PWM outputs
- period_start  out  1  one-cycle pulse on each period wrap

## Operation
- MAX = 2^PWM_W−1. The counter cnt runs 0..MAX−1, so the period is MAX cycles.
- The load condition is load = !en | (cnt == MAX−1).
- On load, cnt←0. Otherwise, when en=1, cnt←cnt+1. While en=0, cnt is held at 0.
- Shadow duty sh[i] loads only on load:
  - mode[i]=0: duty_i
  - mode[i]=1: lvl_i
- Breathing phase ph is PWM_W+1 bits and wraps freely.
  - Channel phase: p_i = ph + i·2^(PWM_W+1)/CH, truncated to PWM_W+1 bits.
  - Fold: lvl_i = p_i[PWM_W] ? ~p_i[PWM_W−1:0] : p_i[PWM_W−1:0].
  - Resulting sequence: 0..MAX, MAX..0. Each extreme is held for two steps.
- Prescaler presc: on an enabled wrap (en & cnt==MAX−1):
  - if presc==prescale: presc←0 and ph←ph+1
  - else: presc←presc+1
  - The shadow load on that edge uses the pre-increment ph.
- A change to prescale takes effect at the next comparison. If prescale drops below the current presc, presc counts up through its wrap to 0.
- Output: pwm_out[i] ← en & (cnt < sh[i]).
  - sh=0: never high.
  - sh=MAX: high for the whole enabled period.
- period_start ← en & (cnt==MAX−1). It is therefore high while cnt==0 after a wrap. The first period after en rises is not flagged.
- Changes to mode, duty or en mid-period: mode and duty take effect at the next load. en low takes effect on the next edge.

## Timing
- Reset values: cnt=0, presc=0, ph=0, sh=0, pwm_out=0, period_start=0.
- Reset mid-operation clears all state on the next edge. Outputs are low the cycle after reset is sampled.
- pwm_out latency is 1 cycle from the cnt/sh compare.
- Duty latency: a value present at a load edge governs the following MAX-cycle period.
- en 1→0: pwm_out=0 from the next cycle. cnt, presc and ph freeze (cnt forced to 0).
- en 0→1: the period starts that edge with cnt=0, using sh loaded while disabled.
- Breathing full cycle = 2^(PWM_W+1)·(prescale+1)·MAX clock cycles.

## Configuration
- PWM_GAMMA_EN defined: the breathe level is gamma-corrected as g = ((lvl+1)² − 1) >> PWM_W, using a 2·PWM_W-bit product. This gives g(0)=0 and g(MAX)=MAX. Static mode is unaffected.
- PWM_GAMMA_EN undefined: breathe duty = lvl (linear). No multiplier is present.

## Structure
- Package pwm_pkg holds:
  - MODE_STATIC and MODE_BREATHE constants
  - a MAX/offset helper function for PWM_W and CH
- Sub-module pwm_fold, one instance per channel:
  - inputs: ph and the channel offset
  - output: PWM_W-bit level
  - contains the fold and the optional gamma stage
- The top module holds cnt, presc, ph, the shadows and the comparators.

## Test plan
Use CH=4, PWM_W=8 unless stated.

- Static levels: mode=0, duty ch0..3 = 0/1/64/255, en=1 → per 255-cycle period, high counts are 0/1/64/255. period_start is spaced exactly 255 cycles apart.
- Mid-period duty change: ch0 duty 64→200 at cnt=100 → the current period shows 64 highs; the next period shows 200.
- Breathe phase: mode=4'hF, prescale=0.
  - Ch0 sh sequence over periods: 0,1,2,…,255,255,254,…,0,0,1.
  - Ch1/ch2/ch3 start at levels 128/255/127.
- Prescaler: prescale=2 → ph advances once every 3 periods. Switching prescale to 0 while presc=2 wraps presc through its maximum before the next step.
- Enable and reset mid-operation:
  - en low at cnt=50 → pwm_out=0 next cycle, cnt=0, ph frozen.
  - en high → waveform resumes from cnt=0.
  - reset asserted mid-period → all outputs 0, ph=0.
- With PWM_GAMMA_EN, breathe ch0 lvl 15/127/255 → sh 0/63/255.
